// File: rtl/ps2_rx_decoder.sv
// PS/2 receive front end: conditions the raw clock/data lines, deframes 11-bit frames and folds E0/F0 prefixes into ps2_key events.
// Optional build macro PS2_PAUSE_FILTER_EN collapses the 8-byte Pause sequence into a single 0x77 extended press.
module ps2_rx_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_strobe,
  output logic        frame_err
);

  // state  | meaning
  // IDLE   | waiting for a start bit (data=0 on a clock falling edge)
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the parity bit
  // STOP   | checking stop bit and odd parity, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, sample_en;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  state_t        state, state_nxt;
  logic [7:0]    shift_reg;
  logic [2:0]    bitcnt;
  logic          par_bit;
  logic          frame_ok, frame_bad;
  logic          ext, brk;
`ifdef PS2_PAUSE_FILTER_EN
  logic          swal;
  logic [2:0]    swal_cnt;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  // filt_cnt runs down while the synchronized clock disagrees with filt_clk; any agreement reloads it
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk  <= 1'b1;
      filt_cnt  <= FW'(FILTER_LEN - 1);
      sample_en <= 1'b0;
    end else begin
      sample_en <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= FW'(FILTER_LEN - 1);
      end else if (filt_cnt == '0) begin
        filt_clk  <= clk_s2;
        filt_cnt  <= FW'(FILTER_LEN - 1);
        sample_en <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt - 1'b1;
      end
    end
  end

  assign tmo_hit = (state != S_IDLE) && !sample_en && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                         tmo_cnt <= '0;
    else if (state == S_IDLE || sample_en) tmo_cnt <= '0;
    else if (!tmo_hit)                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      state_nxt = S_IDLE;
    end else if (sample_en) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
        S_DATA:   if (bitcnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = tmo_hit;
    if (state == S_STOP && sample_en) begin
      frame_ok  = dat_s2 && (^{shift_reg, par_bit});
      frame_bad = !frame_ok;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bitcnt    <= '0;
      par_bit   <= 1'b0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_strobe <= frame_ok;
      frame_err <= frame_bad;
      if (frame_ok) rx_byte <= shift_reg;
      if (sample_en) begin
        case (state)
          S_IDLE:   bitcnt <= '0;
          S_DATA: begin
            shift_reg <= {dat_s2, shift_reg[7:1]};
            bitcnt    <= bitcnt + 3'd1;
          end
          S_PARITY: par_bit <= dat_s2;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key  <= '0;
      ext      <= 1'b0;
      brk      <= 1'b0;
`ifdef PS2_PAUSE_FILTER_EN
      swal     <= 1'b0;
      swal_cnt <= '0;
`endif
    end else if (frame_bad) begin
      ext <= 1'b0;
      brk <= 1'b0;
`ifdef PS2_PAUSE_FILTER_EN
      swal <= 1'b0;
`endif
    end else if (rx_strobe) begin
`ifdef PS2_PAUSE_FILTER_EN
      // Pause: swallow the 7 bytes after E1 and report one extended 0x77 press
      if (swal) begin
        swal_cnt <= swal_cnt - 3'd1;
        if (swal_cnt == 3'd1) begin
          ps2_key <= {~ps2_key[10], 1'b1, 1'b1, 8'h77};
          swal    <= 1'b0;
          ext     <= 1'b0;
          brk     <= 1'b0;
        end
      end else if (rx_byte == 8'hE1 && !ext) begin
        swal     <= 1'b1;
        swal_cnt <= 3'd7;
      end else
`endif
      begin
        case (rx_byte)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
          default: begin
            ps2_key <= {~ps2_key[10], ~brk, ext, rx_byte};
            ext     <= 1'b0;
            brk     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
